// File: rtl/mem_copy_engine.sv
// ============================================================================
// mem_copy_engine: ascending word copy between two ranges of a memory with a
// one-cycle registered read port. Revision: 1.0
// ============================================================================
`default_nettype none

module mem_copy_engine #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [15:0]      length,
    output logic             busy,
    output logic             done,
    output logic [15:0]      rd_addr,
    input  logic [width-1:0] rd_data,
    output logic [15:0]      wr_addr,
    output logic             wr_enable,
    output logic [width-1:0] wr_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COPY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] remaining;

    // Read data lands exactly when its paired write is due, so it feeds the write port directly.
    assign wr_data = rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= 16'd0;
            rd_addr   <= 16'd0;
            wr_addr   <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_enable <= 1'b0;
        end else begin
            done      <= 1'b0;
            wr_enable <= 1'b0;
            if (wr_enable) begin
                wr_addr <= wr_addr + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr   <= src_addr;
                        wr_addr   <= dst_addr;
                        remaining <= length - 16'd1;
                        if (length == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_COPY;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_COPY: begin
                    // Every read issued in this state is written back on the following cycle.
                    wr_enable <= 1'b1;
                    if (remaining == 16'd0) begin
                        state <= S_DRAIN;
                    end else begin
                        rd_addr   <= rd_addr + 16'd1;
                        remaining <= remaining - 16'd1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// tb_mem_copy_engine: directed bench with a memory, a copy model and per-cycle
// comparison of the engine outputs. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_addr = 16'd0;
    logic [15:0] dst_addr = 16'd0;
    logic [15:0] length = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] wr_addr;
    logic        wr_enable;
    logic [15:0] wr_data;

    int checks = 0;
    int errors = 0;

    mem_copy_engine #(.width(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] f(input logic [15:0] a);
        case (a)
            16'h0010: f = 16'h00A1;
            16'h0011: f = 16'h00B2;
            16'h0012: f = 16'h00C3;
            16'h0013: f = 16'h00D4;
            16'hFFFE: f = 16'h1111;
            16'hFFFF: f = 16'h2222;
            16'h0000: f = 16'h3333;
            default:  f = a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory with registered read, always-enabled read port
    logic [15:0] mem [0:65535];
    logic        init_req = 1'b0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 65536; a++) mem[a] <= f(16'(a));
        end else if (wr_enable) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Copy model: one accepted transfer described by its start edge and parameters
    logic        m_active = 1'b0;
    int unsigned m_edge = 0;
    int unsigned m_c0 = 0;
    logic [15:0] m_src = 16'd0;
    logic [15:0] m_dst = 16'd0;
    logic [15:0] m_len = 16'd0;
    logic [15:0] snap [0:63];

    function automatic int unsigned m_end();
        m_end = (m_len == 16'd0) ? m_c0 : m_c0 + m_len + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_edge   <= 0;
        end else begin
            m_edge <= m_edge + 1;
            // Idle again once the done cycle and the return-to-idle edge have passed
            if (start && (!m_active || (m_edge + 1) >= m_end() + 2)) begin
                m_active <= 1'b1;
                m_c0     <= m_edge + 1;
                m_src    <= src_addr;
                m_dst    <= dst_addr;
                m_len    <= length;
                for (int k = 0; k < 64; k++) snap[k] <= mem[16'(src_addr + k)];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp();
        int unsigned d;
        logic eb, ew, ed;
        d = 0;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_wr_enable", wr_enable, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_wr_addr", wr_addr, 0);
        end else begin
            if (m_active) d = m_edge - m_c0;
            eb = m_active && (m_len != 16'd0) && (d <= m_len);
            ew = m_active && (m_len != 16'd0) && (d >= 1) && (d <= m_len);
            ed = m_active && ((m_len == 16'd0) ? (d == 0) : (d == m_len + 1));
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("wr_enable", wr_enable, ew);
            if (eb && d < m_len) chk("rd_addr", rd_addr, 16'(m_src + d));
            if (ew) begin
                chk("wr_addr", wr_addr, 16'(m_dst + d - 1));
                if (d - 1 < 64) chk("wr_data", wr_data, snap[d-1]);
            end
        end
    endtask

    // One clock cycle: compare mid-cycle, then advance past the next rising edge
    task automatic cyc(output logic d, output logic w, output int unsigned e);
        @(negedge clk);
        cmp();
        d = done;
        w = wr_enable;
        e = m_edge;
        @(posedge clk);
        #1;
    endtask

    int unsigned e0;

    task automatic start_copy(input logic [15:0] s, input logic [15:0] ds, input logic [15:0] n);
        logic d, w;
        int unsigned e;
        src_addr = s;
        dst_addr = ds;
        length   = n;
        start    = 1'b1;
        cyc(d, w, e);
        e0    = m_edge;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit inject, output int done_off, output int wr_cnt);
        logic d, w;
        int unsigned e;
        bit found;
        found    = 0;
        done_off = -1;
        wr_cnt   = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            if (inject && i == 2) begin
                src_addr = 16'h0600; dst_addr = 16'h0700; length = 16'd3; start = 1'b1;
            end
            if (inject && i == 4) start = 1'b0;
            cyc(d, w, e);
            if (w) wr_cnt++;
            if (d) begin
                found    = 1;
                done_off = int'(e - e0);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", maxc);
        end
    endtask

    initial begin
        logic d, w;
        int unsigned e;
        int off, wc;

        init_req = 1'b1;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        cyc(d, w, e);
        cyc(d, w, e);
        rst_n = 1'b1;
        cyc(d, w, e);

        // Basic copy
        start_copy(16'h0010, 16'h0100, 16'd4);
        wait_done(20, 0, off, wc);
        chk("basic_done_offset", off, 5);
        chk("basic_wr_count", wc, 4);
        chk("basic_mem0", mem[16'h0100], 16'h00A1);
        chk("basic_mem1", mem[16'h0101], 16'h00B2);
        chk("basic_mem2", mem[16'h0102], 16'h00C3);
        chk("basic_mem3", mem[16'h0103], 16'h00D4);

        // Zero length
        start_copy(16'h0020, 16'h0200, 16'd0);
        wait_done(10, 0, off, wc);
        chk("zero_done_offset", off, 0);
        chk("zero_wr_count", wc, 0);

        // Address wrap
        start_copy(16'hFFFE, 16'hFFFF, 16'd3);
        wait_done(20, 0, off, wc);
        chk("wrap_mem_ffff", mem[16'hFFFF], 16'h1111);
        chk("wrap_mem_0000", mem[16'h0000], 16'h2222);
        chk("wrap_mem_0001", mem[16'h0001], 16'h3333);

        // Start while busy is ignored; start right after done is accepted
        start_copy(16'h0400, 16'h0500, 16'd6);
        wait_done(20, 1, off, wc);
        chk("busy_done_offset", off, 7);
        chk("busy_wr_count", wc, 6);
        chk("busy_ignored_dst", mem[16'h0700], f(16'h0700));
        chk("busy_copy_last", mem[16'h0505], f(16'h0405));
        start_copy(16'h0600, 16'h0700, 16'd3);
        wait_done(20, 0, off, wc);
        chk("after_done_offset", off, 4);
        chk("after_done_mem", mem[16'h0700], f(16'h0600));

        // Reset mid-copy after the second write
        start_copy(16'h0200, 16'h0300, 16'd8);
        cyc(d, w, e);
        cyc(d, w, e);
        cyc(d, w, e);
        chk("pre_reset_wr_enable", wr_enable, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_wr_enable", wr_enable, 0);
        chk("async_busy", busy, 0);
        chk("async_rd_addr", rd_addr, 0);
        cyc(d, w, e);
        chk("reset_no_done", d, 0);
        cyc(d, w, e);
        rst_n = 1'b1;
        cyc(d, w, e);
        chk("reset_mem_w1", mem[16'h0300], f(16'h0200));
        chk("reset_mem_w2", mem[16'h0301], f(16'h0201));
        for (int k = 2; k < 8; k++) chk("reset_mem_untouched", mem[16'(16'h0300 + k)], f(16'(16'h0300 + k)));

        // Fresh start after reset behaves as from power-up
        start_copy(16'h0010, 16'h0120, 16'd4);
        wait_done(20, 0, off, wc);
        chk("post_reset_done_offset", off, 5);
        chk("post_reset_mem3", mem[16'h0123], 16'h00D4);

        // Throughput: 16 back-to-back writes, done in the 18th cycle after E0
        start_copy(16'h0800, 16'h0900, 16'd16);
        wait_done(40, 0, off, wc);
        chk("thru_wr_count", wc, 16);
        chk("thru_done_offset", off, 17);
        chk("thru_mem_last", mem[16'h090F], f(16'h080F));

        cyc(d, w, e);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
